// File: rtl/shr_ift_seq.sv
// Iterative one-bit-per-cycle right shifter with information-flow taint tracking.
// Optional arithmetic (sign-fill) shift is enabled by defining SHR_ARITH_EN.
module shr_ift_seq #(
    parameter int WIDTH   = 4,
    parameter int SHAMT_W = $clog2(WIDTH) + 1,
    parameter int TAINT_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [TAINT_W-1:0] a_t,
    input  logic [SHAMT_W-1:0] b,
    input  logic [TAINT_W-1:0] b_t,
`ifdef SHR_ARITH_EN
    input  logic               arith,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   c,
    output logic [TAINT_W-1:0] c_t,
    output logic [TAINT_W-1:0] out_valid_t
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic [SHAMT_W-1:0]   count_q, count_d;
    logic                 fill_q, fill_d;
    logic [TAINT_W-1:0]   ct_q, ct_d;
    logic [TAINT_W-1:0]   ovt_q, ovt_d;
    logic                 fill_in;
    logic [SHAMT_W-1:0]   count_init;

`ifdef SHR_ARITH_EN
    assign fill_in = arith & a[WIDTH-1];
`else
    assign fill_in = 1'b0;
`endif

    // Shift amounts beyond WIDTH would only shift in more fill bits, so saturate.
    assign count_init = (b > SHAMT_W'(WIDTH)) ? SHAMT_W'(WIDTH) : b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            count_q <= '0;
            fill_q  <= 1'b0;
            ct_q    <= '0;
            ovt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            count_q <= count_d;
            fill_q  <= fill_d;
            ct_q    <= ct_d;
            ovt_q   <= ovt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        count_d = count_q;
        fill_d  = fill_q;
        ct_d    = ct_q;
        ovt_d   = ovt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = a;
                    count_d = count_init;
                    fill_d  = fill_in;
                    ct_d    = a_t | b_t;
                    // Completion time depends on b, so out_valid inherits b's label.
                    ovt_d   = b_t;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (count_q != '0) begin
                    data_d  = {fill_q, data_q[WIDTH-1:1]};
                    count_d = count_q - SHAMT_W'(1);
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign c           = data_q;
    assign c_t         = ct_q;
    assign out_valid_t = ovt_q;

endmodule

// File: tb/tb_shr_ift_seq.sv
// Directed self-checking bench for shr_ift_seq (WIDTH=4, TAINT_W=32).
// Arithmetic-shift vectors run only when SHR_ARITH_EN is defined.
module tb_shr_ift_seq;

    localparam int WIDTH   = 4;
    localparam int SHAMT_W = 3;
    localparam int TAINT_W = 32;

    logic               clk;
    logic               rst_n;
    logic               inValid;
    logic               inReady;
    logic [WIDTH-1:0]   aIn;
    logic [TAINT_W-1:0] aTaint;
    logic [SHAMT_W-1:0] bIn;
    logic [TAINT_W-1:0] bTaint;
    logic               arithIn;
    logic               outValid;
    logic               outReady;
    logic [WIDTH-1:0]   cOut;
    logic [TAINT_W-1:0] cTaint;
    logic [TAINT_W-1:0] outValidTaint;

    int checks;
    int errors;
    int latency;

    shr_ift_seq #(
        .WIDTH  (WIDTH),
        .SHAMT_W(SHAMT_W),
        .TAINT_W(TAINT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (inValid),
        .in_ready   (inReady),
        .a          (aIn),
        .a_t        (aTaint),
        .b          (bIn),
        .b_t        (bTaint),
`ifdef SHR_ARITH_EN
        .arith      (arithIn),
`endif
        .out_valid  (outValid),
        .out_ready  (outReady),
        .c          (cOut),
        .c_t        (cTaint),
        .out_valid_t(outValidTaint)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Presents one operand set, then counts cycles until out_valid; optionally keeps in_valid high.
    task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [TAINT_W-1:0] at,
                                 input logic [SHAMT_W-1:0] bv, input logic [TAINT_W-1:0] bt,
                                 input logic ar, input bit holdValid, output int lat);
        checkOutput("ready_before_accept", {31'd0, inReady}, 32'd1);
        aIn     = av;
        aTaint  = at;
        bIn     = bv;
        bTaint  = bt;
        arithIn = ar;
        inValid = 1'b1;
        nextCycle();
        if (!holdValid) inValid = 1'b0;
        lat = 0;
        while (!outValid && lat < 20) begin
            if (holdValid) checkOutput("ready_low_busy", {31'd0, inReady}, 32'd0);
            nextCycle();
            lat++;
        end
        inValid = 1'b0;
        if (!outValid) checkOutput("out_valid_timeout", {31'd0, outValid}, 32'd1);
        checkOutput("ready_low_done", {31'd0, inReady}, 32'd0);
    endtask

    task automatic runVector(input string tag, input logic [WIDTH-1:0] av, input logic [TAINT_W-1:0] at,
                             input logic [SHAMT_W-1:0] bv, input logic [TAINT_W-1:0] bt, input logic ar,
                             input logic [WIDTH-1:0] expC, input int expLat);
        applyStimulus(av, at, bv, bt, ar, 1'b0, latency);
        checkOutput({tag, "_c"}, {28'd0, cOut}, {28'd0, expC});
        checkOutput({tag, "_ct"}, cTaint, at | bt);
        checkOutput({tag, "_ovt"}, outValidTaint, bt);
        checkOutput({tag, "_lat"}, latency, expLat);
        nextCycle();
        checkOutput({tag, "_idle"}, {30'd0, outValid, inReady}, 32'b01);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        inValid  = 1'b0;
        outReady = 1'b1;
        aIn      = '0;
        aTaint   = '0;
        bIn      = '0;
        bTaint   = '0;
        arithIn  = 1'b0;
        rst_n    = 1'b0;
        #1;
        checkOutput("rst_c", {28'd0, cOut}, 32'd0);
        checkOutput("rst_ct", cTaint, 32'd0);
        checkOutput("rst_ovt", outValidTaint, 32'd0);
        checkOutput("rst_flags", {30'd0, outValid, inReady}, 32'b01);
        #20;
        rst_n = 1'b1;
        nextCycle();

        runVector("t1", 4'b1011, 32'h1, 3'd1, 32'h0, 1'b0, 4'b0101, 2);
        runVector("t2", 4'b1111, 32'h0, 3'd0, 32'h4, 1'b0, 4'b1111, 1);

        // Saturated shift with in_valid held high throughout.
        applyStimulus(4'b1001, 32'h2, 3'd7, 32'h8, 1'b0, 1'b1, latency);
        checkOutput("t3_c", {28'd0, cOut}, 32'd0);
        checkOutput("t3_ct", cTaint, 32'hA);
        checkOutput("t3_ovt", outValidTaint, 32'h8);
        checkOutput("t3_lat", latency, 5);
        nextCycle();

        runVector("b4", 4'b1111, 32'h10, 3'd4, 32'h20, 1'b0, 4'b0000, 5);
        runVector("b3", 4'b1000, 32'h0, 3'd3, 32'h1, 1'b0, 4'b0001, 4);
        runVector("b2", 4'b1100, 32'h40, 3'd2, 32'h0, 1'b0, 4'b0011, 3);

        // Back-pressure: result must hold while out_ready is low.
        outReady = 1'b0;
        applyStimulus(4'b1010, 32'h100, 3'd1, 32'h200, 1'b0, 1'b0, latency);
        for (int i = 0; i < 3; i++) begin
            checkOutput("t4_hold_valid", {31'd0, outValid}, 32'd1);
            checkOutput("t4_hold_c", {28'd0, cOut}, 32'b0101);
            checkOutput("t4_hold_ct", cTaint, 32'h300);
            checkOutput("t4_hold_ovt", outValidTaint, 32'h200);
            checkOutput("t4_hold_ready", {31'd0, inReady}, 32'd0);
            nextCycle();
        end
        outReady = 1'b1;
        nextCycle();
        checkOutput("t4_idle", {30'd0, outValid, inReady}, 32'b01);
        checkOutput("t4_ct_kept", cTaint, 32'h300);
        runVector("t4_next", 4'b0110, 32'h0, 3'd1, 32'h0, 1'b0, 4'b0011, 2);

        // Reset asserted during SHIFT aborts the operation.
        aIn     = 4'b1111;
        aTaint  = 32'h1;
        bIn     = 3'd3;
        bTaint  = 32'h2;
        inValid = 1'b1;
        nextCycle();
        inValid = 1'b0;
        nextCycle();
        rst_n = 1'b0;
        #1;
        checkOutput("t5_c", {28'd0, cOut}, 32'd0);
        checkOutput("t5_ct", cTaint, 32'd0);
        checkOutput("t5_ovt", outValidTaint, 32'd0);
        checkOutput("t5_flags", {30'd0, outValid, inReady}, 32'b01);
        #12;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            nextCycle();
            checkOutput("t5_no_valid", {30'd0, outValid, inReady}, 32'b01);
        end

`ifdef SHR_ARITH_EN
        runVector("t6_arith", 4'b1000, 32'h1, 3'd2, 32'h2, 1'b1, 4'b1110, 3);
        runVector("t6_logic", 4'b1000, 32'h1, 3'd2, 32'h2, 1'b0, 4'b0010, 3);
        runVector("t6_pos", 4'b0111, 32'h0, 3'd4, 32'h0, 1'b1, 4'b0000, 5);
        runVector("t6_sat", 4'b1001, 32'h0, 3'd6, 32'h0, 1'b1, 4'b1111, 5);
`else
        runVector("t6_zero_fill", 4'b1000, 32'h1, 3'd2, 32'h2, 1'b1, 4'b0010, 3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
